// File: rtl/axi_pkg.sv
// Shared definitions for the AXI burst initiator.
//   state_e      : transaction FSM states
//   BURST_INCR   : AxBURST encoding for incrementing bursts
//   RESP_*       : xRESP encodings the initiator distinguishes
//   SIZE_8B      : AxSIZE encoding for 8-byte (64-bit) beats
package axi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AW,
    ST_W,
    ST_B,
    ST_AR,
    ST_R
  } state_e;

  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [2:0] SIZE_8B     = 3'b011;

endpackage

// File: rtl/axi_burst_master_if.sv
// Bundle of every non-clock/reset signal of the burst initiator.
//   cmd_*              : command request (valid/ready) with rw, start address, beats-1
//   wr_data*           : write payload stream into the initiator
//   rd_*               : read payload stream out of the initiator
//   done/err/busy      : transaction status
//   aw*/w*/b*/ar*/r*   : AXI initiator channels
// Modports:
//   master : the initiator's view (axi_burst_master)
//   slave  : the view of whatever drives commands/streams and models the subordinate
interface axi_burst_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int LEN_W  = 4
);

  // command and streams
  logic                cmd_valid;
  logic                cmd_ready;
  logic                cmd_rw;
  logic [ADDR_W-1:0]   cmd_addr;
  logic [LEN_W-1:0]    cmd_len;
  logic [DATA_W-1:0]   wr_data;
  logic                wr_data_valid;
  logic                wr_data_ready;
  logic [DATA_W-1:0]   rd_data;
  logic                rd_valid;
  logic                rd_ready;
  logic                rd_last;
  logic                done;
  logic                err;
  logic                busy;

  // AXI write address / data / response
  logic [ADDR_W-1:0]   awaddr;
  logic                awvalid;
  logic                awready;
  logic [LEN_W-1:0]    awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic                wvalid;
  logic                wready;
  logic                wlast;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                bvalid;
  logic                bready;
  logic [1:0]          bresp;

  // AXI read address / data
  logic                arvalid;
  logic                arready;
  logic [ADDR_W-1:0]   araddr;
  logic [2:0]          arsize;
  logic [1:0]          arburst;
  logic [LEN_W-1:0]    arlen;
  logic                rvalid;
  logic                rready;
  logic                rlast;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;

  modport master (
    input  cmd_valid, cmd_rw, cmd_addr, cmd_len, wr_data, wr_data_valid, rd_ready,
           awready, wready, bvalid, bresp, arready, rvalid, rlast, rdata, rresp,
    output cmd_ready, wr_data_ready, rd_data, rd_valid, rd_last, done, err, busy,
           awaddr, awvalid, awlen, awsize, awburst, wvalid, wlast, wdata, wstrb,
           bready, arvalid, araddr, arsize, arburst, arlen, rready
  );

  modport slave (
    output cmd_valid, cmd_rw, cmd_addr, cmd_len, wr_data, wr_data_valid, rd_ready,
           awready, wready, bvalid, bresp, arready, rvalid, rlast, rdata, rresp,
    input  cmd_ready, wr_data_ready, rd_data, rd_valid, rd_last, done, err, busy,
           awaddr, awvalid, awlen, awsize, awburst, wvalid, wlast, wdata, wstrb,
           bready, arvalid, araddr, arsize, arburst, arlen, rready
  );

endinterface

// File: rtl/axi_beat_counter.sv
// Beat counter shared by the W and R data phases.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : restart the count at zero (at command acceptance)
//   inc        : one beat handshake completed
//   len        : burst length field (beats-1)
//   is_last    : the current beat is beat number len
//   past_last  : the current beat lies beyond len (only reachable on reads)
// The counter is one bit wider than len so a 16-beat burst never wraps, and it
// saturates so an overrunning read stays flagged.
import axi_pkg::*;

module axi_beat_counter #(
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             inc,
  input  logic [LEN_W-1:0] len,
  output logic             is_last,
  output logic             past_last
);

  logic [LEN_W:0] count_q, count_d;
  logic [LEN_W:0] len_ext;

  assign len_ext = {1'b0, len};

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + {{LEN_W{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign is_last   = (count_q == len_ext);
  assign past_last = (count_q >  len_ext);

endmodule

// File: rtl/axi_burst_master.sv
// AXI initiator issuing one INCR burst (up to 16 x 64-bit beats) per command.
//   a_clk, a_rst_n : clock, asynchronous active-low reset
//   bus (master)   : command port, write/read payload streams, status
//                    (done/err/busy) and the five AXI channels
// Write payload and read payload are passed straight through between the
// streams and the W/R channels; only the address phase is registered.
import axi_pkg::*;

module axi_burst_master #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int LEN_W  = 4
) (
  input  logic               a_clk,
  input  logic               a_rst_n,
  axi_burst_master_if.master bus
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              rerr_q, rerr_d;

  logic cmd_fire;
  logic w_fire;
  logic r_fire;
  logic beat_last;
  logic beat_over;
  logic r_beat_err;

  // A new command is refused during the done cycle so that status and the next
  // acceptance never overlap.
  assign cmd_fire = (state_q == ST_IDLE) && !done_q && bus.cmd_valid;
  assign w_fire   = (state_q == ST_W) && bus.wr_data_valid && bus.wready;
  assign r_fire   = (state_q == ST_R) && bus.rvalid && bus.rd_ready;

  // Read framing: a bad response, an early rlast, or a beat beyond len.
  assign r_beat_err = (bus.rresp != RESP_OKAY) || (bus.rlast && !beat_last) || beat_over;

  axi_beat_counter #(
    .LEN_W (LEN_W)
  ) u_beat_cnt (
    .clk       (a_clk),
    .rst_n     (a_rst_n),
    .clear     (cmd_fire),
    .inc       (w_fire || r_fire),
    .len       (len_q),
    .is_last   (beat_last),
    .past_last (beat_over)
  );

  // Fixed attributes and pass-through payload.
  assign bus.awaddr    = addr_q;
  assign bus.araddr    = addr_q;
  assign bus.awlen     = len_q;
  assign bus.arlen     = len_q;
  assign bus.awsize    = SIZE_8B;
  assign bus.arsize    = SIZE_8B;
  assign bus.awburst   = BURST_INCR;
  assign bus.arburst   = BURST_INCR;
  assign bus.wstrb     = '1;
  assign bus.wdata     = bus.wr_data;
  assign bus.rd_data   = bus.rdata;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.cmd_ready = (state_q == ST_IDLE) && !done_q;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    rerr_d  = rerr_q;

    bus.awvalid       = 1'b0;
    bus.wvalid        = 1'b0;
    bus.wlast         = 1'b0;
    bus.wr_data_ready = 1'b0;
    bus.bready        = 1'b0;
    bus.arvalid       = 1'b0;
    bus.rready        = 1'b0;
    bus.rd_valid      = 1'b0;
    bus.rd_last       = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_fire) begin
          // Bursts are always 8-byte aligned.
          addr_d  = bus.cmd_addr & ~{{(ADDR_W-3){1'b0}}, 3'b111};
          len_d   = bus.cmd_len;
          rerr_d  = 1'b0;
          state_d = bus.cmd_rw ? ST_AR : ST_AW;
        end
      end
      ST_AW: begin
        bus.awvalid = 1'b1;
        if (bus.awready) state_d = ST_W;
      end
      ST_W: begin
        bus.wvalid        = bus.wr_data_valid;
        bus.wr_data_ready = bus.wready;
        bus.wlast         = beat_last;
        if (w_fire && beat_last) state_d = ST_B;
      end
      ST_B: begin
        bus.bready = 1'b1;
        if (bus.bvalid) begin
          done_d  = 1'b1;
          err_d   = (bus.bresp != RESP_OKAY);
          state_d = ST_IDLE;
        end
      end
      ST_AR: begin
        bus.arvalid = 1'b1;
        if (bus.arready) state_d = ST_R;
      end
      ST_R: begin
        bus.rready   = bus.rd_ready;
        bus.rd_valid = bus.rvalid;
        bus.rd_last  = bus.rlast;
        if (r_fire) begin
          rerr_d = rerr_q | r_beat_err;
          // Only rlast ends a read; overrunning beats are forwarded and flagged.
          if (bus.rlast) begin
            done_d  = 1'b1;
            err_d   = rerr_q | r_beat_err;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge a_clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rerr_q  <= rerr_d;
    end
  end

endmodule

// File: tb/tb_axi_burst_master.sv
// Self-checking bench for axi_burst_master: a reactive subordinate/stream
// model, a negedge monitor popping scoreboard queues, and a directed sequence.
module tb_axi_burst_master;
  import axi_pkg::*;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 64;
  localparam int LEN_W  = 4;

  logic a_clk   = 1'b0;
  logic a_rst_n = 1'b0;
  always #5 a_clk = ~a_clk;

  axi_burst_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) bus ();

  axi_burst_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .a_clk   (a_clk),
    .a_rst_n (a_rst_n),
    .bus     (bus)
  );

  typedef struct {
    logic [63:0] data;
    logic        last;
  } beat_t;

  beat_t       exp_w[$];
  beat_t       exp_r[$];
  logic        exp_done[$];
  logic [63:0] src_q[$];

  int vec_cnt        = 0;
  int miscompare_cnt = 0;
  int done_cnt       = 0;
  int txn_cnt        = 0;
  int w_beats        = 0;
  int r_beats        = 0;

  logic [31:0] exp_addr = '0;
  logic [3:0]  exp_len  = '0;
  bit          aw_seen  = 0;

  // subordinate / stream configuration
  int          cfg_aw_delay   = 0;
  bit          cfg_gap        = 0;
  logic [1:0]  cfg_bresp      = 2'b00;
  int          cfg_rlast_beat = 0;
  int          cfg_err_beat   = -1;
  bit          cfg_rd_toggle  = 0;
  logic [63:0] rd_base        = '0;

  // handshake flags sampled at negedge, consumed at the next posedge
  bit aw_hs_f = 0, w_hs_f = 0, wl_hs_f = 0, b_hs_f = 0, ar_hs_f = 0, r_hs_f = 0;

  // driver-side state
  int aw_wait = 0;
  bit r_act   = 0;
  int r_idx   = 0;
  bit gap_ph  = 0;

  task automatic check_vec(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      miscompare_cnt++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- monitor ----------------
  initial forever begin
    @(negedge a_clk);
    aw_hs_f = bus.awvalid & bus.awready;
    w_hs_f  = bus.wvalid & bus.wready;
    wl_hs_f = bus.wvalid & bus.wready & bus.wlast;
    b_hs_f  = bus.bvalid & bus.bready;
    ar_hs_f = bus.arvalid & bus.arready;
    r_hs_f  = bus.rvalid & bus.rready;
    if (!a_rst_n) continue;

    if (bus.awvalid) begin
      check_vec("awaddr", bus.awaddr, 64'(exp_addr));
      check_vec("awlen", bus.awlen, 64'(exp_len));
      check_vec("awsize", bus.awsize, 64'(3));
      check_vec("awburst", bus.awburst, 64'(1));
    end
    if (bus.arvalid) begin
      check_vec("araddr", bus.araddr, 64'(exp_addr));
      check_vec("arlen", bus.arlen, 64'(exp_len));
      check_vec("arsize", bus.arsize, 64'(3));
      check_vec("arburst", bus.arburst, 64'(1));
    end

    if (w_hs_f) begin
      check_vec("w_after_aw", 64'(aw_seen), 64'(1));
      check_vec("w_sb_avail", 64'(exp_w.size() > 0), 64'(1));
      if (exp_w.size() > 0) begin
        beat_t b;
        b = exp_w.pop_front();
        check_vec("wdata", bus.wdata, b.data);
        check_vec("wlast", 64'(bus.wlast), 64'(b.last));
        check_vec("wstrb", 64'(bus.wstrb), 64'hFF);
      end
      w_beats++;
    end
    if (aw_hs_f) aw_seen = 1;

    if (bus.rd_valid && bus.rd_ready) begin
      check_vec("r_sb_avail", 64'(exp_r.size() > 0), 64'(1));
      if (exp_r.size() > 0) begin
        beat_t b;
        b = exp_r.pop_front();
        check_vec("rd_data", bus.rd_data, b.data);
        check_vec("rd_last", 64'(bus.rd_last), 64'(b.last));
      end
      r_beats++;
    end

    if (bus.done) begin
      check_vec("done_sb_avail", 64'(exp_done.size() > 0), 64'(1));
      check_vec("cmd_ready_in_done", 64'(bus.cmd_ready), 64'(0));
      if (exp_done.size() > 0) begin
        logic e;
        e = exp_done.pop_front();
        check_vec("err", 64'(bus.err), 64'(e));
      end
      check_vec("w_sb_left", 64'(exp_w.size()), 64'(0));
      check_vec("r_sb_left", 64'(exp_r.size()), 64'(0));
      txn_cnt++;
      $display("txn %0d: done err=%0b wbeats=%0d rbeats=%0d", txn_cnt, bus.err, w_beats, r_beats);
      done_cnt++;
    end
  end

  // ---------------- subordinate + stream driver ----------------
  initial begin
    bus.awready = 0; bus.wready = 0; bus.bvalid = 0; bus.bresp = 0;
    bus.arready = 0; bus.rvalid = 0; bus.rdata = 0; bus.rresp = 0; bus.rlast = 0;
    bus.rd_ready = 1; bus.wr_data = 0; bus.wr_data_valid = 0;
    forever begin
      @(posedge a_clk);
      #1;
      if (bus.awvalid) begin
        bus.awready = (aw_wait >= cfg_aw_delay);
        aw_wait++;
      end else begin
        bus.awready = 0;
        aw_wait = 0;
      end
      bus.wready = 1;
      if (b_hs_f) bus.bvalid = 0;
      if (wl_hs_f) begin
        bus.bvalid = 1;
        bus.bresp  = cfg_bresp;
      end
      bus.arready = bus.arvalid;
      if (ar_hs_f) begin
        r_act = 1;
        r_idx = 0;
      end else if (r_hs_f) begin
        if (bus.rlast) r_act = 0;
        r_idx++;
      end
      bus.rvalid = r_act;
      bus.rdata  = rd_base + 64'(r_idx);
      bus.rresp  = (r_idx == cfg_err_beat) ? RESP_SLVERR : RESP_OKAY;
      bus.rlast  = (r_idx == cfg_rlast_beat);
      bus.rd_ready = cfg_rd_toggle ? ~bus.rd_ready : 1'b1;
      if (w_hs_f && src_q.size() > 0) void'(src_q.pop_front());
      gap_ph = ~gap_ph;
      bus.wr_data_valid = (src_q.size() > 0) && (!cfg_gap || gap_ph);
      bus.wr_data = (src_q.size() > 0) ? src_q[0] : 64'd0;
    end
  end

  // ---------------- sequence helpers ----------------
  task automatic issue(input logic rw, input logic [31:0] addr, input logic [3:0] len);
    int n;
    exp_addr = {addr[31:3], 3'b000};
    exp_len  = len;
    aw_seen  = 0;
    @(posedge a_clk);
    #2;
    bus.cmd_valid = 1;
    bus.cmd_rw    = rw;
    bus.cmd_addr  = addr;
    bus.cmd_len   = len;
    n = 0;
    @(negedge a_clk);
    while (!bus.cmd_ready && n < 50) begin
      @(negedge a_clk);
      n++;
    end
    check_vec("cmd_ready_wait", 64'(bus.cmd_ready), 64'(1));
    @(posedge a_clk);
    #2;
    bus.cmd_valid = 0;
    @(negedge a_clk);
    if (rw) check_vec("arvalid_latency", 64'(bus.arvalid), 64'(1));
    else    check_vec("awvalid_latency", 64'(bus.awvalid), 64'(1));
    check_vec("busy_after_accept", 64'(bus.busy), 64'(1));
    check_vec("cmd_ready_busy", 64'(bus.cmd_ready), 64'(0));
  endtask

  task automatic wait_done(input int start);
    int n;
    n = 0;
    while (done_cnt == start && n < 2000) begin
      @(posedge a_clk);
      n++;
    end
    check_vec("done_seen", 64'(done_cnt != start), 64'(1));
    @(negedge a_clk);
    check_vec("cmd_ready_after_done", 64'(bus.cmd_ready), 64'(1));
    check_vec("busy_after_done", 64'(bus.busy), 64'(0));
  endtask

  task automatic run_write(input logic [31:0] addr, input logic [3:0] len, input int aw_delay,
                           input bit gap, input logic [1:0] bresp, input bit rnd);
    int st;
    logic [63:0] d;
    cfg_aw_delay = aw_delay;
    cfg_gap      = gap;
    cfg_bresp    = bresp;
    for (int i = 0; i <= int'(len); i++) begin
      d = rnd ? {$urandom, $urandom} : 64'((i + 1) * 'h11);
      src_q.push_back(d);
      exp_w.push_back('{data: d, last: (i == int'(len))});
    end
    exp_done.push_back(bresp != 2'b00);
    w_beats = 0;
    st = done_cnt;
    issue(1'b0, addr, len);
    wait_done(st);
    check_vec("w_beats", 64'(w_beats), 64'(int'(len) + 1));
  endtask

  task automatic run_read(input logic [31:0] addr, input logic [3:0] len, input int rlast_beat,
                          input int err_beat, input bit toggle);
    int st;
    logic e;
    cfg_rlast_beat = rlast_beat;
    cfg_err_beat   = err_beat;
    cfg_rd_toggle  = toggle;
    rd_base        = {$urandom, $urandom};
    e = (rlast_beat != int'(len)) || (err_beat >= 0 && err_beat <= rlast_beat);
    for (int i = 0; i <= rlast_beat; i++)
      exp_r.push_back('{data: rd_base + 64'(i), last: (i == rlast_beat)});
    exp_done.push_back(e);
    r_beats = 0;
    st = done_cnt;
    issue(1'b1, addr, len);
    wait_done(st);
    check_vec("r_beats", 64'(r_beats), 64'(rlast_beat + 1));
    cfg_rd_toggle = 0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, want finished");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    int st;
    int n;
    bus.cmd_valid = 0;
    bus.cmd_rw    = 0;
    bus.cmd_addr  = '0;
    bus.cmd_len   = '0;

    repeat (3) @(negedge a_clk);
    check_vec("rst_cmd_ready", 64'(bus.cmd_ready), 64'(1));
    check_vec("rst_busy", 64'(bus.busy), 64'(0));
    check_vec("rst_awvalid", 64'(bus.awvalid), 64'(0));
    check_vec("rst_wvalid", 64'(bus.wvalid), 64'(0));
    check_vec("rst_bready", 64'(bus.bready), 64'(0));
    check_vec("rst_arvalid", 64'(bus.arvalid), 64'(0));
    check_vec("rst_rready", 64'(bus.rready), 64'(0));
    check_vec("rst_done", 64'(bus.done), 64'(0));
    check_vec("rst_err", 64'(bus.err), 64'(0));
    a_rst_n = 1;
    repeat (2) @(negedge a_clk);

    run_write(32'h0000_0010, 4'd3, 0, 1'b0, 2'b00, 1'b0);   // basic write
    run_read (32'h0000_0008, 4'd0, 0, -1, 1'b0);            // single-beat read
    run_write(32'h1234_567D, 4'd5, 5, 1'b1, 2'b00, 1'b1);   // slow AW, gapped source
    run_read (32'h0000_1000, 4'd15, 15, -1, 1'b1);          // 16 beats, backpressure
    run_read (32'h0000_0200, 4'd3, 2, 1, 1'b0);             // early rlast + SLVERR
    run_write(32'h0000_0300, 4'd0, 0, 1'b0, 2'b10, 1'b0);   // single beat, SLVERR resp
    run_read (32'h0000_0400, 4'd1, 3, -1, 1'b0);            // overrun beyond len
    run_write(32'h0000_0800, 4'd15, 1, 1'b0, 2'b00, 1'b1);  // 16-beat write

    // reset in the middle of write beat 2
    cfg_aw_delay = 0;
    cfg_gap      = 0;
    cfg_bresp    = 2'b00;
    for (int i = 0; i < 4; i++) begin
      src_q.push_back(64'hA0 + 64'(i));
      exp_w.push_back('{data: 64'hA0 + 64'(i), last: (i == 3)});
    end
    w_beats = 0;
    issue(1'b0, 32'h0000_0040, 4'd3);
    n = 0;
    while (w_beats < 1 && n < 200) begin
      @(posedge a_clk);
      n++;
    end
    check_vec("rst_mid_reach_beat2", 64'(w_beats), 64'(1));
    @(negedge a_clk);
    #2;
    check_vec("rst_mid_pre_wvalid", 64'(bus.wvalid), 64'(1));
    st = done_cnt;
    a_rst_n = 0;
    #1;
    check_vec("rst_mid_awvalid", 64'(bus.awvalid), 64'(0));
    check_vec("rst_mid_wvalid", 64'(bus.wvalid), 64'(0));
    check_vec("rst_mid_bready", 64'(bus.bready), 64'(0));
    check_vec("rst_mid_busy", 64'(bus.busy), 64'(0));
    check_vec("rst_mid_wr_data_ready", 64'(bus.wr_data_ready), 64'(0));
    src_q.delete();
    exp_w.delete();
    r_act = 0;
    repeat (3) @(posedge a_clk);
    #2;
    a_rst_n = 1;
    repeat (6) @(negedge a_clk);
    check_vec("rst_mid_no_done", 64'(done_cnt), 64'(st));
    check_vec("rst_mid_cmd_ready", 64'(bus.cmd_ready), 64'(1));
    check_vec("rst_mid_busy_after", 64'(bus.busy), 64'(0));

    run_read(32'h0000_0050, 4'd2, 2, -1, 1'b0);             // recovery after reset

    repeat (3) @(negedge a_clk);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompare_cnt);
    $finish;
  end

endmodule

// File: doc/axi_burst_master.md
Name: axi_burst_master

Overview:
- AXI initiator that drives our FIR AXI subordinate (sample RAM write port, result RAM read port) from a simple command interface.
- Issues single INCR bursts of up to 16 beats × 64 bits, one transaction at a time.
- Write data comes from a valid/ready stream; read data leaves on a valid/ready stream.
- Used as the integration-level driver and bench stimulus source for the FIR AXI path.

Parameters:
- ADDR_W, 32, AXI address width.
- DATA_W, 64, AXI data width; size field fixed to log2(DATA_W/8).
- LEN_W, 4, burst length field width (beats-1).

Ports:
- a_clk  in  1  clock
- a_rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when high with cmd_valid
- cmd_rw  in  1  0=write burst, 1=read burst
- cmd_addr  in  ADDR_W  byte start address
- cmd_len  in  LEN_W  beats-1
- wr_data  in  DATA_W  write beat payload
- wr_data_valid  in  1  payload valid
- wr_data_ready  out  1  payload consumed
- rd_data  out  DATA_W  read beat payload
- rd_valid  out  1  read beat valid
- rd_ready  in  1  read sink ready
- rd_last  out  1  final read beat
- done  out  1  one-cycle pulse at transaction end
- err  out  1  valid with done; response or framing error
- busy  out  1  high whenever FSM is not IDLE
- awaddr  out  ADDR_W;  awvalid  out 1;  awready  in 1;  awlen  out LEN_W;  awsize  out 3;  awburst  out 2
- wvalid  out 1;  wready  in 1;  wlast  out 1;  wdata  out DATA_W;  wstrb  out DATA_W/8
- bvalid  in 1;  bready  out 1;  bresp  in 2
- arvalid  out 1;  arready  in 1;  araddr  out ADDR_W;  arsize  out 3;  arburst  out 2;  arlen  out LEN_W
- rvalid  in 1;  rready  out 1;  rlast  in 1;  rdata  in DATA_W;  rresp  in 2

Behaviour:
- Clock/reset: one clock a_clk; a_rst_n asynchronous, active-low.
- Reset values: FSM=IDLE; awvalid, wvalid, bready, arvalid, rready, done, err = 0; busy=0; cmd_ready=1; address/len/counter registers = 0.
- FSM states: IDLE, AW, W, B, AR, R.
- IDLE: cmd_ready=1. On cmd_valid&cmd_ready:
  - latch addr as {cmd_addr[ADDR_W-1:3],3'b000} (low bits forced to zero) and len; clear beat counter;
  - go to AW (cmd_rw=0) or AR (cmd_rw=1).
- Constant drives: awsize=arsize=3'b011; awburst=arburst=2'b01 (INCR); wstrb all ones.
- AW: awvalid=1 with stable awaddr/awlen until awready sampled high, then go to W. W beats are never issued before the AW handshake.
- W:
  - wvalid=wr_data_valid; wr_data_ready=wready; wdata=wr_data (combinational pass-through).
  - wlast=1 when counter==len.
  - Counter increments on each wvalid&wready.
  - On the last-beat handshake go to B.
  - Source stalls (wr_data_valid=0) just hold the state.
- B: bready=1. On bvalid: done=1 next cycle, err=(bresp!=2'b00), return to IDLE.
- AR: arvalid=1 with stable araddr/arlen until arready, then go to R.
- R:
  - rready=rd_ready; rd_valid=rvalid; rd_data=rdata; rd_last=rlast.
  - Counter increments on each rvalid&rready.
  - Sticky error flag is set if any rresp!=0, or if rlast arrives with counter!=len.
  - The transaction ends only on the rlast handshake: done pulse, err=sticky flag, return to IDLE.
  - Beats beyond len without rlast are forwarded and flagged.
- Outside W/R: wr_data_ready=0 and rd_valid=0.
- Single outstanding transaction: cmd_ready=0 from acceptance until the cycle after done.
- Boundaries:
  - len=0 means a single beat with wlast asserted on beat 0.
  - len=15 means 16 beats; the counter must not wrap before the last beat.
  - 4KB boundary crossing is the caller's responsibility; it is not checked.
- Reset mid-transaction: all valids/readies drop immediately (async), FSM returns to IDLE, no done pulse.
- Latency: accept→awvalid/arvalid = 1 cycle. B handshake→done = 1 cycle. rlast handshake→done = 1 cycle.

Decomposition:
- Package axi_pkg holds:
  - state enum;
  - BURST_INCR=2'b01;
  - RESP_OKAY=2'b00, RESP_SLVERR=2'b10;
  - SIZE_8B=3'b011.
- One sub-module: axi_beat_counter (load/clear, increment on handshake, is_last compare against len), reused for the W and R phases.

Test Plan:
- Write len=3 at addr 0x0000_0010, data 0x11..0x44, subordinate always ready → awaddr=0x10, awlen=3, 4 W beats, wlast on beat 4 only, done=1, err=0.
- Read len=0 at addr 0x0000_0008, rresp=OKAY, rlast=1 → single rd_valid beat with rd_last=1, done=1, err=0.
- Write with awready delayed 5 cycles and wr_data_valid gapped every other cycle → awaddr/awlen stable for all 5 cycles, no W beat before AW handshake, exactly len+1 beats.
- Read len=15 with rd_ready toggling → 16 beats delivered in order, no loss under backpressure, done after the 16th beat.
- Read len=3 with rlast on beat 2 and rresp=SLVERR on beat 1 → done with err=1; write with bresp=2'b10 → err=1.
- Assert a_rst_n=0 during W beat 2 → awvalid/wvalid/bready drop in the same cycle, busy=0, cmd_ready=1 after release, no done pulse.
